// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the CPU trace-line checker.
// Holds the FSM state encoding, the literal characters of the line grammar, and the error_code bit positions.
package cpu_trace_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_TIME, S_AT_PC, S_PC, S_COLON, S_SP1, S_GRF, S_ADDR,
    S_SP2, S_ARROW_LT, S_ARROW_EQ, S_SP3, S_DATA, S_SP4, S_ERR
  } state_t;

  typedef enum logic [1:0] {
    FMT_NONE = 2'd0,
    FMT_REG  = 2'd1,
    FMT_MEM  = 2'd2
  } fmt_t;

  localparam logic [7:0] CH_CARET  = 8'h5e;  // '^'
  localparam logic [7:0] CH_AT     = 8'h40;  // '@'
  localparam logic [7:0] CH_COLON  = 8'h3a;  // ':'
  localparam logic [7:0] CH_DOLLAR = 8'h24;  // '$'
  localparam logic [7:0] CH_STAR   = 8'h2a;  // '*'
  localparam logic [7:0] CH_LT     = 8'h3c;  // '<'
  localparam logic [7:0] CH_EQ     = 8'h3d;  // '='
  localparam logic [7:0] CH_HASH   = 8'h23;  // '#'
  localparam logic [7:0] CH_SPACE  = 8'h20;  // ' '

  localparam int ERR_TIME = 0;
  localparam int ERR_PC   = 1;
  localparam int ERR_ADDR = 2;
  localparam int ERR_GRF  = 3;

endpackage

// File: rtl/trace_char_class.sv
// Combinational character classifier: decimal digit, lowercase hex digit, and its 4-bit value.
// Uppercase hex letters are not hex in this grammar.
module trace_char_class (
  input  logic [7:0] char,
  output logic       is_dec,
  output logic       is_hex,
  output logic [3:0] nibble
);

  logic is_alpha_hex;

  always_comb begin
    is_dec       = (char >= 8'h30) && (char <= 8'h39);
    is_alpha_hex = (char >= 8'h61) && (char <= 8'h66);
    is_hex       = is_dec || is_alpha_hex;
    // 'a'..'f' have low nibble 1..6, so adding 9 maps them to 10..15.
    nibble       = is_dec ? char[3:0] : char[3:0] + 4'd9;
  end

endmodule

// File: rtl/cpu_trace_checker.sv
// Character-serial recogniser for CPU trace lines (register and memory writes).
// Reports line format, semantic error bits, and saturating per-kind line counters.
module cpu_trace_checker
  import cpu_trace_pkg::*;
#(
  parameter int          TIME_DIGITS_MAX = 4,
  parameter int          GRF_DIGITS_MAX  = 4,
  parameter int          FREQ_W          = 16,
  parameter logic [31:0] PC_MIN          = 32'h3000,
  parameter logic [31:0] PC_MAX          = 32'h4fff,
  parameter logic [31:0] ADDR_MAX        = 32'h2fff,
  parameter int          CNT_W           = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        char,
  input  logic [FREQ_W-1:0] freq,
  output logic [1:0]        format_type,
  output logic [3:0]        error_code,
  output logic              line_done,
  output logic [CNT_W-1:0]  reg_lines,
  output logic [CNT_W-1:0]  mem_lines,
  output logic [CNT_W-1:0]  err_lines
);

  localparam int TW   = $clog2(10 ** TIME_DIGITS_MAX);
  localparam int GW   = $clog2(10 ** GRF_DIGITS_MAX);
  localparam int MW   = (TW > FREQ_W) ? TW : FREQ_W;
  localparam int DMAX = (TIME_DIGITS_MAX > GRF_DIGITS_MAX) ?
                        ((TIME_DIGITS_MAX > 8) ? TIME_DIGITS_MAX : 8) :
                        ((GRF_DIGITS_MAX > 8) ? GRF_DIGITS_MAX : 8);
  localparam int CW   = $clog2(DMAX + 1);

  localparam logic [CW-1:0] T_LIM   = CW'(TIME_DIGITS_MAX);
  localparam logic [CW-1:0] G_LIM   = CW'(GRF_DIGITS_MAX);
  localparam logic [CW-1:0] HEX_LIM = CW'(8);

  logic       is_dec, is_hex;
  logic [3:0] nibble;

  trace_char_class u_class (
    .char   (char),
    .is_dec (is_dec),
    .is_hex (is_hex),
    .nibble (nibble)
  );

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [TW-1:0]   t_acc;
  logic [GW-1:0]   g_acc;
  logic [31:0]     p_acc, a_acc;
  logic            is_mem;
  logic            clr, ld_t, ld_g, ld_p, ld_a, set_mem, set_reg, done;
  logic [MW-1:0]   half_mask;
  logic [3:0]      ec_n;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    clr     = 1'b0;
    ld_t    = 1'b0;
    ld_g    = 1'b0;
    ld_p    = 1'b0;
    ld_a    = 1'b0;
    set_mem = 1'b0;
    set_reg = 1'b0;
    done    = 1'b0;
    if (char == CH_CARET) begin
      state_n = S_TIME;
      cnt_n   = '0;
      clr     = 1'b1;
    end else begin
      case (state)
        S_IDLE, S_ERR: ;
        S_TIME:
          if (is_dec && cnt < T_LIM) begin
            ld_t = 1'b1; cnt_n = cnt + CW'(1);
          end else if (char == CH_AT && cnt != '0) begin
            state_n = S_AT_PC; cnt_n = '0;
          end else state_n = S_ERR;
        S_AT_PC, S_PC:
          if (is_hex && cnt < HEX_LIM) begin
            ld_p = 1'b1; cnt_n = cnt + CW'(1); state_n = S_PC;
          end else if (char == CH_COLON && cnt == HEX_LIM) state_n = S_COLON;
          else state_n = S_ERR;
        S_COLON, S_SP1:
          if (char == CH_SPACE) state_n = S_SP1;
          else if (char == CH_DOLLAR) begin
            state_n = S_GRF; cnt_n = '0; set_reg = 1'b1;
          end else if (char == CH_STAR) begin
            state_n = S_ADDR; cnt_n = '0; set_mem = 1'b1;
          end else state_n = S_ERR;
        S_GRF:
          if (is_dec && cnt < G_LIM) begin
            ld_g = 1'b1; cnt_n = cnt + CW'(1);
          end else if (cnt != '0 && char == CH_SPACE) state_n = S_SP2;
          else if (cnt != '0 && char == CH_LT) state_n = S_ARROW_LT;
          else state_n = S_ERR;
        S_ADDR:
          if (is_hex && cnt < HEX_LIM) begin
            ld_a = 1'b1; cnt_n = cnt + CW'(1);
          end else if (cnt == HEX_LIM && char == CH_SPACE) state_n = S_SP2;
          else if (cnt == HEX_LIM && char == CH_LT) state_n = S_ARROW_LT;
          else state_n = S_ERR;
        S_SP2:
          if (char == CH_SPACE) state_n = S_SP2;
          else if (char == CH_LT) state_n = S_ARROW_LT;
          else state_n = S_ERR;
        S_ARROW_LT:
          state_n = (char == CH_EQ) ? S_ARROW_EQ : S_ERR;
        S_ARROW_EQ, S_SP3:
          if (char == CH_SPACE) state_n = S_SP3;
          else if (is_hex) begin
            state_n = S_DATA; cnt_n = CW'(1);
          end else state_n = S_ERR;
        S_DATA:
          if (is_hex && cnt < HEX_LIM) cnt_n = cnt + CW'(1);
          else if (cnt == HEX_LIM && char == CH_SPACE) state_n = S_SP4;
          else if (cnt == HEX_LIM && char == CH_HASH) begin
            state_n = S_IDLE; done = 1'b1;
          end else state_n = S_ERR;
        S_SP4:
          if (char == CH_SPACE) state_n = S_SP4;
          else if (char == CH_HASH) begin
            state_n = S_IDLE; done = 1'b1;
          end else state_n = S_ERR;
        default: state_n = S_ERR;
      endcase
    end
  end

  // Semantic checks read the accumulators as they stand when '#' is sampled.
  always_comb begin
    half_mask            = MW'(freq >> 1) - MW'(1);
    ec_n                 = '0;
    ec_n[ERR_TIME]       = |(MW'(t_acc) & half_mask);
    ec_n[ERR_PC]         = (p_acc < PC_MIN) || (p_acc > PC_MAX) || (p_acc[1:0] != 2'b00);
    ec_n[ERR_ADDR]       = is_mem && ((a_acc > ADDR_MAX) || (a_acc[1:0] != 2'b00));
    ec_n[ERR_GRF]        = !is_mem && (32'(g_acc) > 32'd31);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      t_acc       <= '0;
      g_acc       <= '0;
      p_acc       <= '0;
      a_acc       <= '0;
      is_mem      <= 1'b0;
      format_type <= FMT_NONE;
      error_code  <= '0;
      line_done   <= 1'b0;
      reg_lines   <= '0;
      mem_lines   <= '0;
      err_lines   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (clr) begin
        t_acc  <= '0;
        g_acc  <= '0;
        p_acc  <= '0;
        a_acc  <= '0;
        is_mem <= 1'b0;
      end else begin
        if (ld_t)    t_acc  <= TW'(t_acc * TW'(10)) + TW'(nibble);
        if (ld_g)    g_acc  <= GW'(g_acc * GW'(10)) + GW'(nibble);
        if (ld_p)    p_acc  <= {p_acc[27:0], nibble};
        if (ld_a)    a_acc  <= {a_acc[27:0], nibble};
        if (set_mem) is_mem <= 1'b1;
        if (set_reg) is_mem <= 1'b0;
      end
      line_done   <= done;
      format_type <= done ? (is_mem ? FMT_MEM : FMT_REG) : FMT_NONE;
      error_code  <= done ? ec_n : 4'b0000;
      if (done) begin
        if (!is_mem && reg_lines != '1) reg_lines <= reg_lines + CNT_W'(1);
        if (is_mem && mem_lines != '1)  mem_lines <= mem_lines + CNT_W'(1);
        if (ec_n != 4'b0000 && err_lines != '1) err_lines <= err_lines + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Directed bench for cpu_trace_checker: legal/illegal lines, error bits, restart, reset, saturation.
// Counters are built 4 bits wide so saturation is reachable in a short run.
module tb_cpu_trace_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  char = 8'h2e;
  logic [15:0] freq = 16'd2;
  logic [1:0]  format_type;
  logic [3:0]  error_code;
  logic        line_done;
  logic [3:0]  reg_lines, mem_lines, err_lines;

  int total = 0;
  int bad   = 0;
  int exp_reg = 0, exp_mem = 0, exp_err = 0;
  int done_cnt, nz_cnt;
  logic [1:0] last_fmt;
  logic [3:0] last_ec;

  cpu_trace_checker #(.CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .char        (char),
    .freq        (freq),
    .format_type (format_type),
    .error_code  (error_code),
    .line_done   (line_done),
    .reg_lines   (reg_lines),
    .mem_lines   (mem_lines),
    .err_lines   (err_lines)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  task automatic step(input logic [7:0] c);
    @(negedge clk);
    if (line_done) begin
      done_cnt++;
      last_fmt = format_type;
      last_ec  = error_code;
    end
    if (format_type != 2'd0) nz_cnt++;
    char = c;
  endtask

  task automatic send_chars(input string s);
    for (int i = 0; i < s.len(); i++) step(s[i]);
  endtask

  task automatic run_line(input string s);
    done_cnt = 0;
    nz_cnt   = 0;
    last_fmt = 2'd0;
    last_ec  = 4'd0;
    send_chars(s);
    repeat (3) step(8'h2e);
  endtask

  task automatic test_reset;
    #12;
    total++; if (format_type !== 2'd0) begin bad++; $display("FAIL reset_fmt got=%0d want=0", format_type); end
    total++; if (error_code !== 4'd0) begin bad++; $display("FAIL reset_ec got=%b want=0000", error_code); end
    total++; if (line_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", line_done); end
    total++; if ({reg_lines, mem_lines, err_lines} !== 12'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d/%0d want=0/0/0", reg_lines, mem_lines, err_lines);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_well_formed;
    string      lines [13] = '{
      "^242@000030f4: $31 <= 12345678#",
      "^338@00003130: *0000008a <= ffffb528#",
      "^338@00003130: *00003000 <= ffffb528#",
      "^1@00003000:*00002ffc<=00000000#",
      "^242@000030f4: $31 <=   1234abcd   #",
      "^6@00002ffc: $40 <= 00000000#",
      "^9992@00004ffc: $0 <= 00000000#",
      "^4@00005000: $32 <= 00000000#",
      "^4@000030f6:   $7   <=00000000 #",
      "^3@00003004: *00000004 <= 0000000a#",
      "^24^242@000030f4: $31 <= 12345678#",
      "^2x@^242@000030f4: $31 <= 12345678#",
      "^242@000030f4: $31 <= 1234^242@000030f4: $31 <= 12345678#"
    };
    logic [15:0] fr  [13] = '{16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd8, 16'd8,
                              16'd2, 16'd2, 16'd4, 16'd2, 16'd2, 16'd2};
    logic [1:0]  fmt [13] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1,
                              2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1};
    logic [3:0]  ec  [13] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1011, 4'b0000,
                              4'b1010, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 13; i++) begin
      freq = fr[i];
      run_line(lines[i]);
      if (fmt[i] == 2'd1) exp_reg = sat(exp_reg); else exp_mem = sat(exp_mem);
      if (ec[i] != 4'd0) exp_err = sat(exp_err);
      total++; if (done_cnt != 1) begin bad++; $display("FAIL wf%0d_pulses got=%0d want=1", i, done_cnt); end
      total++; if (nz_cnt != 1) begin bad++; $display("FAIL wf%0d_fmt_cycles got=%0d want=1", i, nz_cnt); end
      total++; if (last_fmt !== fmt[i]) begin bad++; $display("FAIL wf%0d_fmt got=%0d want=%0d", i, last_fmt, fmt[i]); end
      total++; if (last_ec !== ec[i]) begin bad++; $display("FAIL wf%0d_ec got=%b want=%b", i, last_ec, ec[i]); end
      total++; if (reg_lines !== 4'(exp_reg)) begin bad++; $display("FAIL wf%0d_reg got=%0d want=%0d", i, reg_lines, exp_reg); end
      total++; if (mem_lines !== 4'(exp_mem)) begin bad++; $display("FAIL wf%0d_mem got=%0d want=%0d", i, mem_lines, exp_mem); end
      total++; if (err_lines !== 4'(exp_err)) begin bad++; $display("FAIL wf%0d_err got=%0d want=%0d", i, err_lines, exp_err); end
    end
  endtask

  task automatic test_malformed;
    string lines [11] = '{
      "^242@000030f4: $31 <= 123456#",
      "^242@000030f4: $31 <=#",
      "^242@000030f4: $31 <= 12345Ab8#",
      "^242@000030f4: $31 <= 123456789#",
      "^242@000030f4: $ 31 <= 12345678#",
      "^12345@000030f4: $31 <= 12345678#",
      "^@000030f4: $31 <= 12345678#",
      "^242@000030F4: $31 <= 12345678#",
      "^242 @000030f4: $31 <= 12345678#",
      "^242@000030f4: $12345 <= 12345678#",
      "242@000030f4: $31 <= 12345678#"
    };
    freq = 16'd2;
    for (int i = 0; i < 11; i++) begin
      run_line(lines[i]);
      total++; if (done_cnt != 0) begin bad++; $display("FAIL bad%0d_pulses got=%0d want=0", i, done_cnt); end
      total++; if (nz_cnt != 0) begin bad++; $display("FAIL bad%0d_fmt_cycles got=%0d want=0", i, nz_cnt); end
    end
    total++; if (reg_lines !== 4'(exp_reg)) begin bad++; $display("FAIL bad_reg got=%0d want=%0d", reg_lines, exp_reg); end
    total++; if (mem_lines !== 4'(exp_mem)) begin bad++; $display("FAIL bad_mem got=%0d want=%0d", mem_lines, exp_mem); end
    total++; if (err_lines !== 4'(exp_err)) begin bad++; $display("FAIL bad_err got=%0d want=%0d", err_lines, exp_err); end
  endtask

  task automatic test_back_to_back;
    freq = 16'd2;
    run_line("^1@00003000: $1 <= 00000000#^2@00003000: *00000000 <= 00000000#");
    exp_reg = sat(exp_reg);
    exp_mem = sat(exp_mem);
    total++; if (done_cnt != 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", done_cnt); end
    total++; if (last_fmt !== 2'd2) begin bad++; $display("FAIL b2b_fmt got=%0d want=2", last_fmt); end
    total++; if (reg_lines !== 4'(exp_reg)) begin bad++; $display("FAIL b2b_reg got=%0d want=%0d", reg_lines, exp_reg); end
    total++; if (mem_lines !== 4'(exp_mem)) begin bad++; $display("FAIL b2b_mem got=%0d want=%0d", mem_lines, exp_mem); end
  endtask

  task automatic test_saturation;
    freq = 16'd2;
    for (int i = 0; i < 7; i++) begin
      run_line("^2@00003000: $1 <= 00000000#");
      exp_reg = sat(exp_reg);
      total++; if (reg_lines !== 4'(exp_reg)) begin bad++; $display("FAIL sat%0d_reg got=%0d want=%0d", i, reg_lines, exp_reg); end
    end
    total++; if (reg_lines !== 4'd15) begin bad++; $display("FAIL sat_final got=%0d want=15", reg_lines); end
  endtask

  task automatic test_reset_mid;
    freq = 16'd2;
    done_cnt = 0;
    nz_cnt   = 0;
    send_chars("^242@000030f4: $31 <= 1234");
    #2 reset = 1'b0;
    #1;
    total++; if ({reg_lines, mem_lines, err_lines} !== 12'd0) begin
      bad++; $display("FAIL midrst_cnt got=%0d/%0d/%0d want=0/0/0", reg_lines, mem_lines, err_lines);
    end
    @(negedge clk);
    reset = 1'b1;
    exp_reg = 0; exp_mem = 0; exp_err = 0;
    run_line("5678#");
    total++; if (done_cnt != 0) begin bad++; $display("FAIL midrst_pulses got=%0d want=0", done_cnt); end
    total++; if (reg_lines !== 4'd0) begin bad++; $display("FAIL midrst_reg got=%0d want=0", reg_lines); end

    freq = 16'd8;
    send_chars("^6@00002ffc: $40 <= 00000000#");
    @(negedge clk);
    total++; if (line_done !== 1'b1 || error_code !== 4'b1011) begin
      bad++; $display("FAIL pulse_before_rst got=%b/%b want=1/1011", line_done, error_code);
    end
    #2 reset = 1'b0;
    #1;
    total++; if (line_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", line_done); end
    total++; if (format_type !== 2'd0) begin bad++; $display("FAIL rst_fmt got=%0d want=0", format_type); end
    total++; if (error_code !== 4'd0) begin bad++; $display("FAIL rst_ec got=%b want=0000", error_code); end
    total++; if ({reg_lines, err_lines} !== 8'd0) begin
      bad++; $display("FAIL rst_cnt got=%0d/%0d want=0/0", reg_lines, err_lines);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset;
    test_well_formed;
    test_malformed;
    test_back_to_back;
    test_saturation;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
